// File: rtl/ycbcr444_to_422.sv
// ycbcr444_to_422: converts aligned 4:4:4 Y/Cb/Cr video into 4:2:2.
// Each even/odd pixel pair shares one Cb and one Cr sample, both the
// horizontal average of the pair. Cb goes out with the even pixel and Cr
// with the odd pixel. All outputs, syncs included, lag the inputs by
// exactly two enabled clock cycles.

// delayLine: fixed-length shift register with clock enable and async clear.
module delayLine #(
    parameter int DELAY = 2,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DELAY];

    // Shift the taps on every enabled cycle; clear them all on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DELAY; i++) begin
                taps[i] <= '0;
            end
        end else if (ce) begin
            taps[0] <= din;
            for (int i = 1; i < DELAY; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DELAY-1];

endmodule

module ycbcr444_to_422 #(
    parameter int WIDTH = 8,
    parameter int ROUND = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_de,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_cb,
    input  logic [WIDTH-1:0] in_cr,
    output logic             out_de,
    output logic             out_hsync,
    output logic             out_vsync,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_c,
    output logic             out_cflag
);

    // Rounding term added before the halving shift; zero means truncation.
    localparam logic [WIDTH:0] RND_ADD = (ROUND != 0) ? (WIDTH+1)'(1) : '0;

    // The sum is one bit wider than a sample, so the average cannot overflow.
    function automatic logic [WIDTH-1:0] avg2(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b} + RND_ADD;
        return sum[WIDTH:1];
    endfunction

    // Tag of the pixel currently on the input: 0 = even, 1 = odd.
    logic phase;

    // Stage-1 copy of the previous enabled input pixel.
    logic             s1_de;
    logic             s1_phase;
    logic [WIDTH-1:0] s1_y;
    logic [WIDTH-1:0] s1_cb;
    logic [WIDTH-1:0] s1_cr;

    // Cr average of the current pair, emitted with the odd pixel.
    logic [WIDTH-1:0] cr_hold;

    // Next values for the output stage and the held Cr.
    logic [WIDTH-1:0] nxt_y;
    logic [WIDTH-1:0] nxt_c;
    logic             nxt_cflag;
    logic [WIDTH-1:0] nxt_hold;

    // Toggle the tag on every active pixel and clear it during blanking,
    // so that every line starts on an even pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= 1'b0;
        end else if (ce) begin
            phase <= in_de ? ~phase : 1'b0;
        end
    end

    // Stage 1: register the input pixel together with its de flag and tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_de    <= 1'b0;
            s1_phase <= 1'b0;
            s1_y     <= '0;
            s1_cb    <= '0;
            s1_cr    <= '0;
        end else if (ce) begin
            s1_de    <= in_de;
            s1_phase <= phase;
            s1_y     <= in_y;
            s1_cb    <= in_cb;
            s1_cr    <= in_cr;
        end
    end

    // Stage 2 selection. An even pixel in s1 is paired with the odd pixel
    // now on the input. With no partner (odd-length line) it averages with
    // itself. An odd pixel in s1 emits the Cr computed one cycle earlier.
    always_comb begin
        nxt_y     = '0;
        nxt_c     = '0;
        nxt_cflag = 1'b0;
        nxt_hold  = cr_hold;
        if (s1_de) begin
            nxt_y = s1_y;
            if (s1_phase) begin
                nxt_c     = cr_hold;
                nxt_cflag = 1'b1;
            end else if (in_de && phase) begin
                nxt_c    = avg2(s1_cb, in_cb);
                nxt_hold = avg2(s1_cr, in_cr);
            end else begin
                nxt_c    = s1_cb;
                nxt_hold = s1_cr;
            end
        end
    end

    // Stage 2 registers: the 4:2:2 output and the held Cr average.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_de    <= 1'b0;
            out_y     <= '0;
            out_c     <= '0;
            out_cflag <= 1'b0;
            cr_hold   <= '0;
        end else if (ce) begin
            out_de    <= s1_de;
            out_y     <= nxt_y;
            out_c     <= nxt_c;
            out_cflag <= nxt_cflag;
            cr_hold   <= nxt_hold;
        end
    end

    // Syncs pass through unchanged, delayed to match the data path.
    delayLine #(
        .DELAY (2),
        .WIDTH (2)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .din  ({in_hsync, in_vsync}),
        .dout ({out_hsync, out_vsync})
    );

endmodule

// File: tb/tb_ycbcr444_to_422.sv
// tb_ycbcr444_to_422: drives a ROUND=1 and a ROUND=0 converter with the same
// stimulus and compares both against a pixel-history reference model.
module tb_ycbcr444_to_422;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ce = 1'b1;
    logic         in_de = 1'b0, in_hsync = 1'b0, in_vsync = 1'b0;
    logic [W-1:0] in_y = '0, in_cb = '0, in_cr = '0;

    logic         o1_de, o1_hs, o1_vs, o1_cflag;
    logic [W-1:0] o1_y, o1_c;
    logic         o0_de, o0_hs, o0_vs, o0_cflag;
    logic [W-1:0] o0_y, o0_c;

    int compared = 0;
    int failed   = 0;

    // Reference history: one entry per enabled cycle since reset release.
    localparam int HMAX = 4096;
    bit hde [HMAX];
    bit hhs [HMAX];
    bit hvs [HMAX];
    int hy  [HMAX];
    int hcb [HMAX];
    int hcr [HMAX];
    int hpos[HMAX];
    int n = 0;

    ycbcr444_to_422 #(.WIDTH(W), .ROUND(1)) dut1 (
        .clk(clk), .rst(rst), .ce(ce),
        .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr),
        .out_de(o1_de), .out_hsync(o1_hs), .out_vsync(o1_vs),
        .out_y(o1_y), .out_c(o1_c), .out_cflag(o1_cflag)
    );

    ycbcr444_to_422 #(.WIDTH(W), .ROUND(0)) dut0 (
        .clk(clk), .rst(rst), .ce(ce),
        .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr),
        .out_de(o0_de), .out_hsync(o0_hs), .out_vsync(o0_vs),
        .out_y(o0_y), .out_c(o0_c), .out_cflag(o0_cflag)
    );

    always #5 clk = ~clk;

    function automatic int avgm(input int a, input int b, input int r);
        return r ? (a + b + 1) / 2 : (a + b) / 2;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Output now visible reflects history entry n-2; its chroma comes from
    // its position within the active run and its neighbour in that run.
    task automatic checkDuts();
        int j;
        int e_de, e_hs, e_vs, e_y, e_c1, e_c0, e_fl;
        e_de = 0; e_hs = 0; e_vs = 0; e_y = 0; e_c1 = 0; e_c0 = 0; e_fl = 0;
        if (n >= 2) begin
            j = n - 2;
            e_hs = int'(hhs[j]);
            e_vs = int'(hvs[j]);
            if (hde[j]) begin
                e_de = 1;
                e_y  = hy[j];
                if (hpos[j] % 2 == 1) begin
                    e_fl = 1;
                    e_c1 = avgm(hcr[j-1], hcr[j], 1);
                    e_c0 = avgm(hcr[j-1], hcr[j], 0);
                end else if (hde[j+1]) begin
                    e_c1 = avgm(hcb[j], hcb[j+1], 1);
                    e_c0 = avgm(hcb[j], hcb[j+1], 0);
                end else begin
                    e_c1 = hcb[j];
                    e_c0 = hcb[j];
                end
            end
        end
        checkOutput("r1_de",    32'(o1_de),    32'(e_de));
        checkOutput("r1_hsync", 32'(o1_hs),    32'(e_hs));
        checkOutput("r1_vsync", 32'(o1_vs),    32'(e_vs));
        checkOutput("r1_y",     32'(o1_y),     32'(e_y));
        checkOutput("r1_c",     32'(o1_c),     32'(e_c1));
        checkOutput("r1_cflag", 32'(o1_cflag), 32'(e_fl));
        checkOutput("r0_de",    32'(o0_de),    32'(e_de));
        checkOutput("r0_y",     32'(o0_y),     32'(e_y));
        checkOutput("r0_c",     32'(o0_c),     32'(e_c0));
        checkOutput("r0_cflag", 32'(o0_cflag), 32'(e_fl));
    endtask

    // Drive one cycle of inputs, record enabled samples, then check outputs.
    task automatic applyStimulus(input bit de, input bit hs, input bit vs,
                                 input int y, input int cb, input int cr,
                                 input bit cev);
        in_de = de; in_hsync = hs; in_vsync = vs;
        in_y = W'(y); in_cb = W'(cb); in_cr = W'(cr);
        ce = cev;
        @(posedge clk);
        if (rst === 1'b1 && cev && n < HMAX) begin
            hde[n]  = de;
            hhs[n]  = hs;
            hvs[n]  = vs;
            hy[n]   = y;
            hcb[n]  = cb;
            hcr[n]  = cr;
            hpos[n] = !de ? 0 : ((n > 0 && hde[n-1]) ? hpos[n-1] + 1 : 0);
            n++;
        end
        if (rst !== 1'b1) n = 0;
        #1;
        checkDuts();
    endtask

    task automatic blank(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        bit rde;

        // Reset held with random inputs: outputs must stay cleared.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom),
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), 1);
        rst = 1'b1;
        n = 0;

        // Four pixels right after release: first output on the second cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 30 + i, 40 + i, 50 + i, 1);
            if (i == 0) checkOutput("first_de_early", 32'(o1_de), 0);
            if (i == 1) checkOutput("first_de_valid", 32'(o1_de), 1);
        end
        blank(3);

        // Pair averaging example for both rounding modes.
        applyStimulus(1, 0, 0, 10, 100, 200, 1);
        applyStimulus(1, 0, 0, 20, 101, 203, 1);
        checkOutput("pair_y0", 32'(o1_y), 10);
        checkOutput("pair_cb_r1", 32'(o1_c), 101);
        checkOutput("pair_cb_r0", 32'(o0_c), 100);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("pair_y1", 32'(o1_y), 20);
        checkOutput("pair_cr_r1", 32'(o1_c), 202);
        checkOutput("pair_cr_r0", 32'(o0_c), 201);
        checkOutput("pair_cflag1", 32'(o1_cflag), 1);
        blank(2);

        // Top-of-range sum: 255 + 254.
        applyStimulus(1, 0, 0, 1, 255, 255, 1);
        applyStimulus(1, 0, 0, 2, 254, 254, 1);
        checkOutput("max_cb_r1", 32'(o1_c), 255);
        checkOutput("max_cb_r0", 32'(o0_c), 254);
        blank(3);

        // Odd-length line: last pixel self-averages, then blanking.
        applyStimulus(1, 0, 0, 5, 50, 80, 1);
        applyStimulus(1, 0, 0, 6, 60, 90, 1);
        checkOutput("odd_c0", 32'(o1_c), 55);
        applyStimulus(1, 0, 0, 7, 70, 99, 1);
        checkOutput("odd_c1", 32'(o1_c), 85);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("odd_c2", 32'(o1_c), 70);
        checkOutput("odd_cflag2", 32'(o1_cflag), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("odd_blank_de", 32'(o1_de), 0);
        checkOutput("odd_blank_c", 32'(o1_c), 0);
        blank(2);

        // Clock-enable stall between the two pixels of a pair.
        applyStimulus(1, 0, 0, 10, 100, 200, 1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom),
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), 0);
        applyStimulus(1, 0, 0, 20, 101, 203, 1);
        checkOutput("stall_cb", 32'(o1_c), 101);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("stall_cr", 32'(o1_c), 202);
        blank(2);

        // Lines of 5 and 4 pixels, hsync in the single-cycle gap.
        applyStimulus(0, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 60 + i, 70 + 3 * i, 90 + 5 * i, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 80 + i, 20 + 7 * i, 10 + 9 * i, 1);
            if (i == 1) begin
                checkOutput("line2_first_de", 32'(o1_de), 1);
                checkOutput("line2_first_cflag", 32'(o1_cflag), 0);
            end
        end
        blank(3);

        // Asynchronous reset with an even pixel sitting in stage 1.
        applyStimulus(1, 0, 0, 11, 111, 121, 1);
        applyStimulus(1, 0, 0, 12, 112, 122, 1);
        applyStimulus(1, 0, 0, 13, 113, 123, 1);
        rst = 1'b0;
        n = 0;
        #1;
        checkOutput("areset_de", 32'(o1_de), 0);
        checkOutput("areset_y", 32'(o1_y), 0);
        checkOutput("areset_c", 32'(o1_c), 0);
        checkOutput("areset_cflag", 32'(o1_cflag), 0);
        applyStimulus(1, 0, 0, 14, 114, 124, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        applyStimulus(1, 0, 0, 40, 10, 20, 1);
        applyStimulus(1, 0, 0, 41, 13, 27, 1);
        checkOutput("post_reset_cb", 32'(o1_c), 12);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("post_reset_cr", 32'(o1_c), 24);
        blank(2);

        // Randomized traffic: random run lengths, syncs and enable gaps.
        rde = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (rde) rde = ($urandom_range(0, 11) != 0);
            else     rde = ($urandom_range(0, 2) == 0);
            applyStimulus(rde, $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0,
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), $urandom_range(0, 9) != 0);
        end
        blank(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
